// File: rtl/alu.sv
// rtl/alu.sv - registered 16-bit ALU with parallel result and branch-compare flag
// Operation result is selected by funct3; compare flag by funct3[1:0].

module alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOUT,
  output logic             cmp
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_NE = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;
  localparam logic [1:0] CMP_GE = 2'd3;

  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic             cmp_q, cmp_d;

  // Shared adder: subtract is A + ~B + 1.
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;

  assign is_sub = (funct3 == OP_SUB);
  assign b_op   = B ^ {WIDTH{is_sub}};
  assign sum    = A + b_op + WIDTH'(is_sub);

  // One right-shifting barrel serves all shifts; left shift runs on bit-reversed A.
  logic [SHW-1:0]   sh;
  logic             shift_left;
  logic             fill;
  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] sr_in;
  logic [WIDTH-1:0] stage [0:SHW];
  logic [WIDTH-1:0] sr_out;
  logic [WIDTH-1:0] sr_out_rev;
  logic [WIDTH-1:0] shift_res;

  assign sh         = B[SHW-1:0];
  assign shift_left = (funct3 == OP_SLL);
  assign fill       = (funct3 == OP_SRA) & A[WIDTH-1];

  always_comb begin
    a_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i] = A[WIDTH-1-i];
    end
  end

  assign sr_in    = shift_left ? a_rev : A;
  assign stage[0] = sr_in;

  for (genvar g = 0; g < SHW; g++) begin : g_shift
    assign stage[g+1] = sh[g] ? {{(2**g){fill}}, stage[g][WIDTH-1:2**g]} : stage[g];
  end

  assign sr_out = stage[SHW];

  always_comb begin
    sr_out_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sr_out_rev[i] = sr_out[WIDTH-1-i];
    end
  end

  assign shift_res = shift_left ? sr_out_rev : sr_out;

  always_comb begin
    aluout_d = '0;
    case (funct3)
      OP_ADD,
      OP_SUB:  aluout_d = sum;
      OP_XOR:  aluout_d = A ^ B;
      OP_OR:   aluout_d = A | B;
      OP_AND:  aluout_d = A & B;
      OP_SLL,
      OP_SRL,
      OP_SRA:  aluout_d = shift_res;
      default: aluout_d = '0;
    endcase
  end

  // Signed less-than: differing signs decide directly, else the sign of A-B.
  logic [WIDTH-1:0] diff;
  logic             eq;
  logic             lt;

  assign diff = A - B;
  assign eq   = (A == B);
  assign lt   = (A[WIDTH-1] != B[WIDTH-1]) ? A[WIDTH-1] : diff[WIDTH-1];

  always_comb begin
    cmp_d = 1'b0;
    case (funct3[1:0])
      CMP_EQ:  cmp_d = eq;
      CMP_NE:  cmp_d = ~eq;
      CMP_LT:  cmp_d = lt;
      CMP_GE:  cmp_d = ~lt;
      default: cmp_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      aluout_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      aluout_q <= aluout_d;
      cmp_q    <= cmp_d;
    end
  end

  assign ALUOUT = aluout_q;
  assign cmp    = cmp_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.

module tb_alu;

  logic        CLK;
  logic        reset;
  logic [2:0]  funct3;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] ALUOUT;
  logic        cmp;

  int checks;
  int errors;

  alu #(.WIDTH(16)) dut (
    .CLK    (CLK),
    .reset  (reset),
    .funct3 (funct3),
    .A      (A),
    .B      (B),
    .ALUOUT (ALUOUT),
    .cmp    (cmp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] f, input logic [15:0] a,
                      input logic [15:0] b);
    @(negedge CLK);
    reset  = rst;
    funct3 = f;
    A      = a;
    B      = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic vec(input string tag, input logic [2:0] f, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp_out, input logic exp_cmp);
    step(1'b0, f, a, b);
    check({tag, "_out"}, ALUOUT, exp_out);
    check({tag, "_cmp"}, {15'd0, cmp}, {15'd0, exp_cmp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    funct3 = 3'd0;
    A      = 16'd0;
    B      = 16'd0;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i + 1), 16'hA5A5 + 16'(i), 16'h1234);
      check($sformatf("rst%0d_out", i), ALUOUT, 16'h0000);
      check($sformatf("rst%0d_cmp", i), {15'd0, cmp}, 16'h0000);
    end

    vec("release",  3'd0, 16'd4,      16'd5,      16'd9,      1'b0);

    vec("sub",      3'd1, 16'd10,     16'd4,      16'd6,      1'b1);
    vec("xor",      3'd2, 16'd14,     16'd7,      16'd9,      1'b0);
    vec("or",       3'd3, 16'd5,      16'd6,      16'd7,      1'b0);
    vec("and",      3'd4, 16'd11,     16'd5,      16'd1,      1'b0);
    vec("add_wrap", 3'd0, 16'h7FFF,   16'd1,      16'h8000,   1'b0);
    vec("sub_wrap", 3'd1, 16'h8000,   16'd1,      16'h7FFF,   1'b1);

    vec("sll",      3'd5, 16'd3,      16'd2,      16'd12,     1'b1);
    vec("srl",      3'd6, 16'd7,      16'd2,      16'd1,      1'b0);
    vec("sra",      3'd7, 16'hF830,   16'd1,      16'hFC18,   1'b0);
    vec("srl15",    3'd6, 16'h8000,   16'd15,     16'h0001,   1'b1);
    vec("sra15",    3'd7, 16'h8000,   16'd15,     16'hFFFF,   1'b0);
    vec("sra15p",   3'd7, 16'h7FFF,   16'd15,     16'h0000,   1'b1);
    vec("sll15",    3'd5, 16'h0001,   16'd15,     16'h8000,   1'b1);
    vec("sll_b17",  3'd5, 16'd1,      16'd17,     16'd2,      1'b1);
    vec("sll0",     3'd5, 16'h1235,   16'd0,      16'h1235,   1'b1);
    vec("srl0",     3'd6, 16'h8001,   16'd16,     16'h8001,   1'b1);
    vec("sra0",     3'd7, 16'h8001,   16'd0,      16'h8001,   1'b0);

    vec("eq1",      3'd0, 16'd1,      16'd1,      16'd2,      1'b1);
    vec("eq0",      3'd4, 16'd2,      16'd1,      16'd0,      1'b0);
    vec("ne1",      3'd1, 16'd2,      16'd1,      16'd1,      1'b1);
    vec("ne0",      3'd5, 16'd1,      16'd1,      16'd2,      1'b0);
    vec("lt1",      3'd2, 16'd0,      16'd1,      16'd1,      1'b1);
    vec("lt0",      3'd6, 16'd3,      16'd1,      16'd1,      1'b0);
    vec("lt_eq",    3'd6, 16'd1,      16'd1,      16'd0,      1'b0);
    vec("ge_eq",    3'd3, 16'd1,      16'd1,      16'd1,      1'b1);
    vec("ge1",      3'd7, 16'd3,      16'd1,      16'd1,      1'b1);
    vec("ge0",      3'd7, 16'd0,      16'd1,      16'd0,      1'b0);

    vec("slt_neg",  3'd2, 16'hFFFF,   16'd1,      16'hFFFE,   1'b1);
    vec("sge_mm",   3'd3, 16'h8000,   16'h7FFF,   16'hFFFF,   1'b0);
    vec("slt_mm",   3'd2, 16'h8000,   16'h7FFF,   16'hFFFF,   1'b1);
    vec("sge_pm",   3'd3, 16'h7FFF,   16'h8000,   16'hFFFF,   1'b1);

    step(1'b1, 3'd0, 16'd4, 16'd5);
    check("midrst_out", ALUOUT, 16'h0000);
    check("midrst_cmp", {15'd0, cmp}, 16'h0000);
    vec("post_rst", 3'd0, 16'd4,      16'd5,      16'd9,      1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
